// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin mux / arbiter family.
package rr_mux_pkg;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  function automatic int unsigned next_idx(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 32'd0 : i + 1;
  endfunction

  // Forward distance from 'from' to 'to' on a ring of n slots.
  function automatic int unsigned ring_dist(input int unsigned from, input int unsigned to,
                                            input int unsigned n);
    return (to >= from) ? to - from : to + n - from;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// First set request at or after ptr, wrapping modulo NCH; purely combinational.
module rr_pick import rr_mux_pkg::*; #(
  parameter int NCH  = 4,
  parameter int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);
  always_comb begin
    int unsigned best;
    found = 1'b0;
    idx   = '0;
    best  = NCH;
    // Closest requester downstream of ptr wins; no modulo hardware needed.
    for (int i = 0; i < NCH; i++) begin
      if (req[i] && (ring_dist(32'(ptr), i, NCH) < best)) begin
        best  = ring_dist(32'(ptr), i, NCH);
        found = 1'b1;
        idx   = SELW'(i);
      end
    end
  end
endmodule

// File: rtl/rr_mux_reg.sv
// N-channel mux with direct or round-robin selection, one-beat output register
// and valid/ready handshakes on all ports.
module rr_mux_reg import rr_mux_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);
  logic [WIDTH-1:0] out_data_q, out_data_d, pick_data;
  logic [SELW-1:0]  out_ch_q, out_ch_d, rr_ptr_q, rr_ptr_d, rr_idx, cand;
  logic             out_valid_q, out_valid_d;
  logic             load, rr_found, cand_ok, xfer;

  rr_pick #(.NCH(NCH), .SELW(SELW)) u_pick (
    .req   (in_valid),
    .ptr   (rr_ptr_q),
    .found (rr_found),
    .idx   (rr_idx)
  );

  assign load = !out_valid_q || out_ready;

  always_comb begin
    if (mode == MODE_RR) begin
      cand    = rr_idx;
      cand_ok = rr_found;
    end else begin
      cand    = sel;
      cand_ok = (32'(sel) < NCH);
    end
  end

  // Direct mode grants ready without looking at valid; only RR sees in_valid.
  always_comb begin
    in_ready  = '0;
    pick_data = '0;
    xfer      = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      in_ready[i] = rst_n && load && cand_ok && (cand == SELW'(i));
      if (in_ready[i]) pick_data = in_data[i*WIDTH +: WIDTH];
      if (in_ready[i] && in_valid[i]) xfer = 1'b1;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = pick_data;
        out_ch_d   = cand;
        rr_ptr_d   = SELW'(next_idx(32'(cand), NCH));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output and a valid/ready handshake on every port.
- Two modes: direct select (the selector picks the channel) or fair round-robin among the channels that have valid data.
- Sits between several producer channels and one consumer, as the successor to the fixed 4:1 combinational mux.
- Provides backpressure, one-beat buffering and the index of the channel that supplied each beat.

Parameters:
- WIDTH, 4, data bits per channel.
- NCH, 4, number of input channels (2..16, need not be a power of two).
- SELW, $clog2(NCH), selector and channel-index width (derived; do not override).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- mode  in  1  0 = direct select, 1 = round-robin.
- sel  in  SELW  channel to use in direct mode.
- in_data  in  NCH*WIDTH  flattened; channel i is bits [i*WIDTH +: WIDTH].
- in_valid  in  NCH  per-channel valid.
- in_ready  out  NCH  per-channel ready; combinational.
- out_data  out  WIDTH  registered data.
- out_ch  out  SELW  registered index of the source channel.
- out_valid  out  1  registered valid.
- out_ready  in  1  consumer ready.

Behaviour:
- Reset, sampled on the clk edge while rst_n=0:
  - out_valid=0, out_data=0, out_ch=0, rr_ptr=0.
  - Any beat held in the register is discarded.
  - in_ready is all-0 while rst_n=0.
- load = !out_valid || out_ready (combinational). The output register accepts a new beat only when load=1.
- Channel selection, cand, computed combinationally:
  - mode=0: cand=sel. If sel>=NCH, there is no candidate.
  - mode=1: the first i with in_valid[i]=1, scanning from rr_ptr upward and wrapping modulo NCH. If no channel is valid, there is no candidate.
- in_ready[i] = rst_n && load && (cand exists) && (i==cand). At most one bit is set.
  - Combinational path in_valid -> in_ready exists in mode 1 only.
  - In mode 0, ready does not depend on valid.
- Transfer on channel i happens when in_valid[i] && in_ready[i]. At the next edge:
  - out_data <= channel i data, out_ch <= i, out_valid <= 1.
  - rr_ptr <= i+1, wrapping to 0 after NCH-1. rr_ptr updates on grants in either mode.
- No transfer while load=1: out_valid <= 0 at the next edge. out_data and out_ch hold their last values.
- out_valid=1 and out_ready=0: out_data, out_ch and out_valid hold; all in_ready=0.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 beat per cycle while out_ready is held at 1. Simultaneous drain and load is allowed in the same cycle.
- Mode or sel changes take effect combinationally in the same cycle. A beat already in the register is unaffected.
- rr_ptr is a mod-NCH counter. Non-power-of-two NCH must wrap correctly, e.g. NCH=3: 2 -> 0.
- Mid-operation reset: a held beat is lost; the first cycle after rst_n returns to 1 behaves as if from power-up.

Decomposition:
- Shared package rr_mux_pkg holds:
  - MODE_DIRECT=1'b0, MODE_RR=1'b1.
  - The function for next index modulo N.
- Sub-module rr_pick(NCH):
  - Inputs: req vector and ptr.
  - Outputs: found and idx, the first set bit at or after ptr with wraparound, combinational.
  - Reused by future arbiters.
- The top level contains load, the output register and rr_ptr.

Test Plan:
- Reset, flush and recovery:
  - Hold rst_n=0 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0000.
  - Assert rst_n=0 for 1 cycle while out_valid=1 and out_ready=0 -> out_valid=0 after that edge.
  - After release -> the first grant starts from ch0.
- Direct mode, NCH=4, WIDTH=4:
  - Inputs a=3, b=5, c=9, d=F, all valid, out_ready=1; sel=2 -> in_ready=0100; next cycle out_data=9, out_ch=2.
  - sel=3 -> out_data=F.
- Round-robin fairness:
  - mode=1, all 4 valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3, one beat per cycle.
  - Only ch1 and ch3 valid -> sequence 1,3,1,3.
- Backpressure:
  - out_valid=1 with out_data=5, out_ready=0 for 3 cycles -> data/ch/valid hold and in_ready=0000.
  - out_ready=1 -> the next beat loads in the same cycle; no beat is lost or duplicated (bench scoreboard checks per-channel order).
- Non-power-of-two NCH=3:
  - All valid, RR mode -> out_ch 0,1,2,0.
  - Direct sel=3 -> no grant, in_ready=000, out_valid falls to 0.
- Empty inputs:
  - No in_valid for 2 cycles -> out_valid=0 and rr_ptr unchanged.
  - Then only ch2 valid -> out_ch=2 and rr_ptr=3.
